// File: rtl/key_debounce_port.sv
// key_debounce_port
//
// Input stage for the general-purpose input ports of the MCU. Raw push-button
// inputs are normalised to "1 = pressed" and passed through a two-flop
// synchroniser. Each key is then debounced against a shared sample-tick
// prescaler, and every press latches a sticky event bit. Firmware clears
// events with a per-key clear vector.
//
// Optional feature (compile-time macro KEY_AUTOREPEAT_EN):
//   While a key stays pressed, its event bit is set again after REPEAT_DELAY
//   sample ticks and then every REPEAT_RATE ticks. With the macro undefined,
//   events are raised only on press edges.
//
// Parameters:
//   N_KEYS       number of keys (1..8)
//   ACTIVE_LOW   1: a raw key reads 0 when pressed; 0: it reads 1 when pressed
//   SAMPLE_DIV   clk cycles per sample tick
//   STABLE_CNT   consecutive disagreeing ticks needed to flip the debounced level
//   REPEAT_DELAY ticks held before the first auto-repeat (macro builds only)
//   REPEAT_RATE  ticks between later auto-repeats (macro builds only)
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   key_sw   in   [N_KEYS-1:0] raw asynchronous button inputs
//   evt_clr  in   [7:0] bit i high clears press event i (bits >= N_KEYS ignored)
//   port_in  out  [15:0] {sticky events[7:0], debounced levels[7:0]},
//                 bits for keys >= N_KEYS read 0
//   key_irq  out  registered OR of all event bits

module key_debounce_port #(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int SAMPLE_DIV   = 50000,
  parameter int STABLE_CNT   = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_sw,
  input  logic [7:0]        evt_clr,
  output logic [15:0]       port_in,
  output logic              key_irq
);

  // ------------------------------------------------------------------------
  // Derived widths and constants
  // ------------------------------------------------------------------------
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = ($clog2(STABLE_CNT + 1) > 0) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

  // Keys that exist; everything above reads as zero.
  localparam logic [8:0] KEY_MASK9 = (9'd1 << N_KEYS) - 9'd1;
  localparam logic [7:0] KEY_MASK  = KEY_MASK9[7:0];

  // ------------------------------------------------------------------------
  // Normalisation and synchronisation
  // ------------------------------------------------------------------------
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  assign pressed = (ACTIVE_LOW != 0) ? ~key_sw : key_sw;

  // The synchroniser resets to "released" so that a key held through reset
  // is treated as a fresh press once reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------------------
  // Sample-tick prescaler: counts 0..SAMPLE_DIV-1, tick on the last count
  // ------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ------------------------------------------------------------------------
  // Per-key debounce
  //
  // On each tick a key whose synchronised value disagrees with its debounced
  // level advances its counter; any agreeing tick restarts the count, so
  // bouncing contacts never accumulate. The level flips on the tick that
  // completes STABLE_CNT consecutive disagreements, and the counter never
  // reaches STABLE_CNT itself.
  // ------------------------------------------------------------------------
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] level_d;
  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [CW-1:0]     cnt_d [N_KEYS];
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Auto-repeat
  // ------------------------------------------------------------------------
  logic [N_KEYS-1:0] rep_fire;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = ($clog2(REP_MAX + 1) > 0) ? $clog2(REP_MAX + 1) : 1;

  localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]     rep_cnt_q [N_KEYS];
  logic [RW-1:0]     rep_cnt_d [N_KEYS];
  // Per-key threshold select: 0 = waiting for the first repeat (REPEAT_DELAY),
  // 1 = in steady repeat (REPEAT_RATE).
  logic [N_KEYS-1:0] rep_rate_q;
  logic [N_KEYS-1:0] rep_rate_d;
  logic [RW-1:0]     rep_last;

  // The counter counts ticks since the press edge (or since the last repeat);
  // the tick that would bring it to the threshold fires the repeat and
  // restarts the count. A release edge wins over a coincident repeat.
  always_comb begin
    rep_fire   = '0;
    rep_rate_d = rep_rate_q;
    rep_last   = REP_DELAY_LAST;
    for (int i = 0; i < N_KEYS; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      rep_last     = rep_rate_q[i] ? REP_RATE_LAST : REP_DELAY_LAST;
      if (!level_q[i] || fall[i]) begin
        rep_cnt_d[i]  = '0;
        rep_rate_d[i] = 1'b0;
      end else if (tick) begin
        if (rep_cnt_q[i] == rep_last) begin
          rep_fire[i]   = 1'b1;
          rep_cnt_d[i]  = '0;
          rep_rate_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_rate_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_rate_q <= rep_rate_d;
      for (int i = 0; i < N_KEYS; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`else
  assign rep_fire = '0;

  // The repeat settings have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  // ------------------------------------------------------------------------
  // Sticky events and interrupt
  //
  // Events are kept as a full 8-bit vector so the clear vector maps one to
  // one; bits of absent keys are masked to zero. A set in the same cycle as
  // a clear wins so that no press is lost.
  // ------------------------------------------------------------------------
  logic [7:0] evt_q;
  logic [7:0] evt_d;
  logic [7:0] evt_set;
  logic [7:0] level8;
  logic       key_irq_q;

  always_comb begin
    evt_set               = '0;
    evt_set[N_KEYS-1:0]   = rise | rep_fire;
    evt_d                 = ((evt_q & ~evt_clr) | evt_set) & KEY_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q     <= '0;
      key_irq_q <= 1'b0;
    end else begin
      evt_q     <= evt_d;
      key_irq_q <= |evt_q;
    end
  end

  always_comb begin
    level8              = '0;
    level8[N_KEYS-1:0]  = level_q;
  end

  assign port_in = {evt_q, level8};
  assign key_irq = key_irq_q;

endmodule
